// File: rtl/uart_rx_fifo.sv
// UART receiver with start/stop/parity checks, output FIFO and sticky errors.
// Ports: clk, rst_n, RX serial in, rd_en pop, clr_err; rx_data head word,
// rdy non-empty, fifo_cnt fill level, framing_err, parity_err, overrun.
module uart_rx_fifo #(
    parameter int CLK_DIV    = 2604,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            RX,
    input  logic                            rd_en,
    input  logic                            clr_err,
    output logic [DATA_BITS-1:0]            rx_data,
    output logic                            rdy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_cnt,
    output logic                            framing_err,
    output logic                            parity_err,
    output logic                            overrun
);

    localparam int DW = DATA_BITS;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [11:0] HALF = 12'(CLK_DIV / 2 - 1);
    localparam logic [11:0] FULL = 12'(CLK_DIV - 1);
    localparam logic [3:0]  LAST = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, BREAK
    } state_t;

    state_t         state, state_d;
    logic           rx_meta, rxs;
    logic [11:0]    baud_cnt, baud_d;
    logic [3:0]     bit_cnt, bit_d;
    logic [DW-1:0]  shreg, shreg_d;
    logic           pbad, pbad_d;
    logic           tick;
    logic           push, set_fe, set_pe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= RX;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            pbad     <= 1'b0;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_d;
            bit_cnt  <= bit_d;
            shreg    <= shreg_d;
            pbad     <= pbad_d;
        end
    end

    assign tick = (baud_cnt == 12'd0);

    always_comb begin
        state_d = state;
        baud_d  = baud_cnt;
        bit_d   = bit_cnt;
        shreg_d = shreg;
        pbad_d  = pbad;
        push    = 1'b0;
        set_fe  = 1'b0;
        set_pe  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rxs) begin
                    baud_d  = HALF;
                    state_d = START;
                end
            end
            START: begin
                if (!tick) begin
                    baud_d = baud_cnt - 12'd1;
                end else if (rxs) begin
                    // glitch shorter than half a bit: not a start
                    state_d = IDLE;
                end else begin
                    baud_d  = FULL;
                    bit_d   = '0;
                    pbad_d  = 1'b0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (!tick) begin
                    baud_d = baud_cnt - 12'd1;
                end else begin
                    // LSB arrives first, so shift in from the top
                    shreg_d = {rxs, shreg[DW-1:1]};
                    bit_d   = bit_cnt + 4'd1;
                    baud_d  = FULL;
                    if (bit_cnt == LAST)
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (!tick) begin
                    baud_d = baud_cnt - 12'd1;
                end else begin
                    pbad_d  = ((^shreg) ^ rxs) != 1'(PARITY_ODD);
                    baud_d  = FULL;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (!tick) begin
                    baud_d = baud_cnt - 12'd1;
                end else if (!rxs) begin
                    set_fe  = 1'b1;
                    state_d = BREAK;
                end else if (pbad) begin
                    set_pe  = 1'b1;
                    state_d = IDLE;
                end else begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            BREAK: begin
                // line held low: wait for idle before hunting for a start
                if (rxs)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] cnt;
    logic          full, pop, wr, drop;

    assign rdy  = (cnt != '0);
    assign full = (cnt == CW'(FIFO_DEPTH));
    assign pop  = rd_en && rdy;
    // a simultaneous pop frees a slot, so a full FIFO still accepts
    assign wr   = push && (!full || pop);
    assign drop = push && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (wr) begin
                mem[wptr] <= shreg;
                wptr      <= wptr + AW'(1);
            end
            if (pop)
                rptr <= rptr + AW'(1);
            cnt <= cnt + CW'(wr) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            framing_err <= 1'b0;
            parity_err  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            framing_err <= set_fe | (framing_err & ~clr_err);
            parity_err  <= set_pe | (parity_err & ~clr_err);
            overrun     <= drop | (overrun & ~clr_err);
        end
    end

    assign rx_data  = mem[rptr];
    assign fifo_cnt = cnt;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: plain and even-parity instances,
// CLK_DIV=16, 8 data bits, 4-entry FIFO.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx0 = 1'b1, rx1 = 1'b1;
    logic       rd0 = 1'b0, rd1 = 1'b0;
    logic       clr0 = 1'b0, clr1 = 1'b0;
    logic [7:0] d0, d1;
    logic       rdy0, rdy1;
    logic [2:0] cnt0, cnt1;
    logic       fe0, pe0, ov0, fe1, pe1, ov1;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLK_DIV(16), .DATA_BITS(8), .PARITY_EN(0),
        .PARITY_ODD(0), .FIFO_DEPTH(4)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .RX(rx0), .rd_en(rd0),
        .clr_err(clr0), .rx_data(d0), .rdy(rdy0),
        .fifo_cnt(cnt0), .framing_err(fe0),
        .parity_err(pe0), .overrun(ov0)
    );

    uart_rx_fifo #(
        .CLK_DIV(16), .DATA_BITS(8), .PARITY_EN(1),
        .PARITY_ODD(0), .FIFO_DEPTH(4)
    ) u_par (
        .clk(clk), .rst_n(rst_n), .RX(rx1), .rd_en(rd1),
        .clr_err(clr1), .rx_data(d1), .rdy(rdy1),
        .fifo_cnt(cnt1), .framing_err(fe1),
        .parity_err(pe1), .overrun(ov1)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rx1 = v;
        else     rx0 = v;
        repeat (16) @(negedge clk);
    endtask

    task automatic send(input bit sel, input logic [7:0] d,
                        input bit hp, input bit p, input bit stop);
        drive(sel, 1'b0);
        for (int i = 0; i < 8; i++)
            drive(sel, d[i]);
        if (hp)
            drive(sel, p);
        drive(sel, stop);
    endtask

    task automatic pop(input bit sel);
        if (sel) rd1 = 1'b1;
        else     rd0 = 1'b1;
        @(negedge clk);
        rd0 = 1'b0;
        rd1 = 1'b0;
    endtask

    task automatic clear(input bit sel);
        if (sel) clr1 = 1'b1;
        else     clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        clr1 = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rdy", 32'(rdy0), 32'd0);
        chk("rst_cnt", 32'(cnt0), 32'd0);
        chk("rst_data", 32'(d0), 32'd0);
        chk("rst_flags", {29'd0, fe0, pe0, ov0}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // two back-to-back frames
        send(0, 8'hA5, 0, 0, 1);
        send(0, 8'h3C, 0, 0, 1);
        repeat (4) @(negedge clk);
        chk("t1_rdy", 32'(rdy0), 32'd1);
        chk("t1_head", 32'(d0), 32'hA5);
        chk("t1_cnt", 32'(cnt0), 32'd2);
        pop(0);
        chk("t1_second", 32'(d0), 32'h3C);
        chk("t1_cnt1", 32'(cnt0), 32'd1);
        pop(0);
        chk("t1_empty", 32'(rdy0), 32'd0);
        chk("t1_cnt0", 32'(cnt0), 32'd0);

        // short glitch is not a start bit
        rx0 = 1'b0;
        repeat (4) @(negedge clk);
        rx0 = 1'b1;
        repeat (24) @(negedge clk);
        chk("t2_rdy", 32'(rdy0), 32'd0);
        chk("t2_flags", {29'd0, fe0, pe0, ov0}, 32'd0);
        send(0, 8'h55, 0, 0, 1);
        repeat (4) @(negedge clk);
        chk("t2_data", 32'(d0), 32'h55);
        chk("t2_cnt", 32'(cnt0), 32'd1);
        pop(0);

        // even parity
        send(1, 8'h07, 1, 1, 1);
        repeat (4) @(negedge clk);
        chk("t3_good_rdy", 32'(rdy1), 32'd1);
        chk("t3_good_data", 32'(d1), 32'h07);
        chk("t3_good_pe", 32'(pe1), 32'd0);
        pop(1);
        send(1, 8'h07, 1, 0, 1);
        repeat (4) @(negedge clk);
        chk("t3_bad_cnt", 32'(cnt1), 32'd0);
        chk("t3_bad_pe", 32'(pe1), 32'd1);
        clear(1);
        chk("t3_clr_pe", 32'(pe1), 32'd0);

        // framing error then long break
        send(0, 8'h81, 0, 0, 0);
        repeat (40) @(negedge clk);
        rx0 = 1'b1;
        repeat (24) @(negedge clk);
        chk("t4_fe", 32'(fe0), 32'd1);
        chk("t4_cnt", 32'(cnt0), 32'd0);
        clear(0);
        chk("t4_clr_fe", 32'(fe0), 32'd0);
        send(0, 8'h42, 0, 0, 1);
        repeat (4) @(negedge clk);
        chk("t4_data", 32'(d0), 32'h42);
        chk("t4_cnt1", 32'(cnt0), 32'd1);
        pop(0);

        // overrun on the fifth frame
        for (int i = 1; i <= 5; i++)
            send(0, 8'(i), 0, 0, 1);
        repeat (4) @(negedge clk);
        chk("t5_cnt", 32'(cnt0), 32'd4);
        chk("t5_ov", 32'(ov0), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            chk("t5_drain", 32'(d0), 32'(i));
            pop(0);
        end
        chk("t5_empty", 32'(rdy0), 32'd0);
        clear(0);
        chk("t5_clr_ov", 32'(ov0), 32'd0);

        // pop in the stop-sample cycle of the fifth frame
        for (int i = 1; i <= 4; i++)
            send(0, 8'(i), 0, 0, 1);
        fork
            send(0, 8'h05, 0, 0, 1);
            begin
                repeat (154) @(negedge clk);
                rd0 = 1'b1;
                @(negedge clk);
                rd0 = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        chk("t5b_ov", 32'(ov0), 32'd0);
        chk("t5b_cnt", 32'(cnt0), 32'd4);
        for (int i = 2; i <= 5; i++) begin
            chk("t5b_drain", 32'(d0), 32'(i));
            pop(0);
        end

        // reset during data bit 3
        send(0, 8'h11, 0, 0, 1);
        repeat (4) @(negedge clk);
        chk("t6_pre_cnt", 32'(cnt0), 32'd1);
        rx0 = 1'b0;
        repeat (16) @(negedge clk);
        rx0 = 1'b1;
        repeat (56) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("t6_rst_cnt", 32'(cnt0), 32'd0);
        chk("t6_rst_rdy", 32'(rdy0), 32'd0);
        chk("t6_rst_data", 32'(d0), 32'd0);
        send(0, 8'hF0, 0, 0, 1);
        repeat (4) @(negedge clk);
        chk("t6_data", 32'(d0), 32'hF0);
        chk("t6_cnt", 32'(cnt0), 32'd1);
        chk("t6_flags", {29'd0, fe0, pe0, ov0}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver for the quadcopter command/telemetry link, the next generation of the single-byte receiver. It has the following capabilities:
- Configurable baud divisor, data width and optional parity.
- Start-bit validation and stop-bit checking.
- An output FIFO, so the command layer can drain bytes without overrun at back-to-back frame rates.
- Sticky error flags for framing, parity and overrun.

Parameters:
CLK_DIV, 2604, clk cycles per bit (2604 = 19200 baud at 50 MHz); legal range 8..4095
DATA_BITS, 8, data bits per frame, LSB first; legal 5..9
PARITY_EN, 0, 1 = parity bit follows data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored when PARITY_EN=0)
FIFO_DEPTH, 4, received-word FIFO entries; power of 2, 2..16

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
RX  in  1  serial input, asynchronous to clk, idle high
rd_en  in  1  pop head of FIFO; ignored when FIFO empty
clr_err  in  1  clears framing_err, parity_err, overrun
rx_data  out  DATA_BITS  FIFO head word (first-word fall-through); valid only when rdy=1
rdy  out  1  FIFO non-empty
fifo_cnt  out  $clog2(FIFO_DEPTH)+1  number of words held
framing_err  out  1  sticky: stop bit sampled 0
parity_err  out  1  sticky: parity mismatch
overrun  out  1  sticky: good frame dropped because FIFO full

Behaviour:
- Synchroniser: RX passes through a 2-flop synchroniser, reset to 1. All frame logic uses the synchronised value `rxs`.
- Reset values: FIFO empty, rdy=0, fifo_cnt=0, all error flags 0, state IDLE, rx_data=0.
- States are IDLE, START, DATA, PARITY, STOP and BREAK. The baud counter counts down and a sample is taken in the cycle it reads 0.
- IDLE: when rxs=0, load baud_cnt = CLK_DIV/2 - 1 (integer divide) and go to START.
- START: at the sample, if rxs=1 the start was false; return to IDLE with no flags and no push. If rxs=0, load baud_cnt = CLK_DIV - 1, clear bit_cnt and go to DATA.
- DATA: at each sample, shift rxs into the MSB of the shift register, increment bit_cnt and reload CLK_DIV - 1. After DATA_BITS samples, go to PARITY if PARITY_EN, else STOP.
- PARITY: sample one bit. The error condition is XOR(data, parity bit) != PARITY_ODD. Latch the result and go to STOP.
- STOP, sampled at mid stop bit:
  - rxs=1 and no parity error: push the word and go to IDLE immediately, so the next start edge is seen within half a bit.
  - rxs=1 with parity error: discard the word, set parity_err, go to IDLE.
  - rxs=0: discard the word, set framing_err, go to BREAK.
- BREAK: wait for rxs=1, then go to IDLE. No frames are started while RX is held low.
- Latency: rdy asserts the cycle after the STOP sample cycle.
- FIFO:
  - Circular buffer with read/write pointers that wrap modulo FIFO_DEPTH.
  - rx_data always shows the head entry.
  - rd_en with rdy=1 pops; the next entry (or stale data with rdy=0) appears the following cycle.
- Push while full with no pop: the word is dropped, overrun is set and FIFO contents are unchanged.
- Push and pop in the same cycle: both are performed, fifo_cnt is unchanged, and there is no overrun even when full.
- Pop while empty has no effect.
- Error flags: each is set by its event. clr_err clears all three. If a set and clr_err occur in the same cycle, the set wins.
- Reset mid-frame: immediate return to IDLE, FIFO flushed, flags cleared. The next valid falling edge after reset starts a fresh frame.

Test Plan:
1. CLK_DIV=16, DATA_BITS=8, no parity: send 0xA5, then 0x3C back-to-back with one stop bit each. Expect rdy=1 with rx_data=0xA5 and fifo_cnt=2; after rd_en, rx_data=0x3C; after a second rd_en, rdy=0.
2. Drive RX low for 4 cycles (< CLK_DIV/2), then high. Expect return to IDLE with rdy=0 and all flags 0; a following 0x55 frame is received correctly.
3. PARITY_EN=1, PARITY_ODD=0:
   - Send 0x07 with parity bit 1: pushed, no error.
   - Send 0x07 with parity bit 0: not pushed, parity_err=1.
   - Then assert clr_err: parity_err=0.
4. Send 0x81 with stop bit 0, then hold RX low 40 cycles, then high. Expect framing_err=1, nothing pushed, no frame started during the low hold; the next 0x42 frame is received.
5. FIFO_DEPTH=4, send 5 frames 0x01..0x05 with no reads. Expect fifo_cnt=4, overrun=1, and drained order 0x01..0x04. Repeat with rd_en asserted in the 5th STOP-sample cycle: overrun=0 and 0x05 is retained.
6. Assert rst_n low during DATA bit 3, release, then send 0xF0. Expect FIFO empty after reset, then rx_data=0xF0 and flags 0.
